// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time (IDLE→REQ→WAIT→HOLD), with a response timeout that parks in ERR.
// Optional build macro IFU_MISALIGN_CHK_EN faults a fetch from a pc that is not word-aligned.
//
// state | meaning
// IDLE  | latch pc as fetch address and instruction pc
// REQ   | memory request valid, address stable until accepted
// WAIT  | waiting for read data, wait counter running
// HOLD  | instruction offered to decode until accepted
// ERR   | fetch fault, sticky until reset
module ifu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_wen,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_ERR
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        req_valid_q;
   logic        inst_valid_q;
   logic        fetch_err_q;
   logic [31:0] addr_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic [15:0] wait_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
         addr_q       <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         wait_cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               addr_q    <= pc;
               inst_pc_q <= pc;
`ifdef IFU_MISALIGN_CHK_EN
               if (pc[1:0] != 2'b00) begin
                  state_q     <= S_ERR;
                  fetch_err_q <= 1'b1;
               end else begin
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
               end
`else
               state_q     <= S_REQ;
               req_valid_q <= 1'b1;
`endif
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state_q     <= S_WAIT;
                  req_valid_q <= 1'b0;
                  wait_cnt_q  <= '0;
               end
            end
            S_WAIT: begin
               // a response on the timeout cycle still wins
               if (imem_rsp_valid) begin
                  inst_q       <= imem_rsp_data;
                  state_q      <= S_HOLD;
                  inst_valid_q <= 1'b1;
               end else if (wait_cnt_q == TMO_LAST) begin
                  state_q     <= S_ERR;
                  fetch_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  state_q      <= S_IDLE;
                  inst_valid_q <= 1'b0;
               end
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q      <= S_IDLE;
               req_valid_q  <= 1'b0;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = req_valid_q & ~rst;
   assign inst_valid     = inst_valid_q & ~rst;
   assign pc_wen         = inst_valid_q & inst_ready & ~rst;
   assign imem_req_addr  = addr_q;
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: bench acts as PC register, memory and decode; expectations come from
// per-fetch timestamps (request, acceptance, response latency, retirement).
module tb_ifu;
   localparam int TMO     = 4;
   localparam int NCYCLES = 3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = 32'h8000_0000;
   logic        pc_wen;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_err;

   always #5 clk = ~clk;

   ifu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .fetch_err(fetch_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // fetch timeline, -1 = not scheduled
   int req_from  = -1;
   int acc_cyc   = -1;
   int rsp_cyc   = -1;
   int stale_cyc = -1;
   int hold_from = -1;
   int err_from  = -1;
   int start_at  = -1;
   int rst_left  = 0;
   int lat;
   bit rst_prev  = 1'b1;
   bit pcw_prev  = 1'b0;
   bit pending;
   bit exp_req, exp_iv, exp_pcw, exp_err;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic [31:0] rnd;

   initial begin
      for (int cyc = 0; cyc < NCYCLES; cyc++) begin
         @(posedge clk);
         #1;
         if (pcw_prev) pc = pc + 32'd4;

         if (cyc < 3) begin
            rst = 1'b1;
         end else if (rst_left > 0) begin
            rst = 1'b1;
            rst_left--;
         end else if (err_from >= 0 && cyc >= err_from + 3) begin
            rst = 1'b1;
            rst_left = $urandom_range(0, 2);
         end else if (cyc > 20 && $urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            rst_left = $urandom_range(0, 2);
         end else begin
            rst = 1'b0;
         end

         if (rst) begin
            req_from = -1; acc_cyc = -1; rsp_cyc = -1;
            hold_from = -1; err_from = -1; start_at = -1;
            if (cyc >= 3) begin
               rnd = $urandom;
               pc = ($urandom_range(0, 3) == 0) ? rnd : {rnd[31:2], 2'b00};
            end
         end else if (rst_prev) begin
            start_at  = cyc;
            stale_cyc = cyc;
         end
         rst_prev = rst;

         if (start_at == cyc) begin
`ifdef IFU_MISALIGN_CHK_EN
            if (pc[1:0] != 2'b00) err_from = cyc + 1;
            else begin
               req_from = cyc + 1;
               exp_addr = pc;
            end
`else
            req_from = cyc + 1;
            exp_addr = pc;
`endif
         end

         if (cyc < 12) begin
            imem_req_ready = 1'b1;
            inst_ready     = 1'b1;
         end else begin
            imem_req_ready = ($urandom_range(0, 9) < 6);
            inst_ready     = ($urandom_range(0, 9) < 6);
         end

         pending = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc <= rsp_cyc);
         if (!rst && cyc == rsp_cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = exp_data;
         end else if (cyc == stale_cyc || (!pending && $urandom_range(0, 3) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
         end

         exp_req = !rst && req_from >= 0 && cyc >= req_from;
         exp_iv  = !rst && hold_from >= 0 && cyc >= hold_from;
         exp_pcw = exp_iv && inst_ready;
         exp_err = err_from >= 0 && cyc >= err_from;

         #1;
         check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
         if (exp_req) check("req_addr", imem_req_addr, exp_addr);
         check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
         if (exp_iv) begin
            check("inst", inst, exp_data);
            check("inst_pc", inst_pc, exp_addr);
         end
         check("pc_wen", {31'd0, pc_wen}, {31'd0, exp_pcw});
         check("req_inst_excl", {31'd0, imem_req_valid & inst_valid}, 32'd0);
         if (!rst) check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});

         if (exp_req && imem_req_ready) begin
            acc_cyc  = cyc;
            req_from = -1;
            lat      = (cyc < 12) ? 1 : $urandom_range(1, 6);
            rsp_cyc  = cyc + lat;
            exp_data = (cyc < 12) ? 32'h0000_0413 : $urandom;
            if (lat <= TMO) hold_from = cyc + lat + 1;
            else            err_from  = cyc + TMO + 1;
         end
         if (exp_pcw) begin
            hold_from = -1;
            start_at  = cyc + 1;
         end
         pcw_prev = exp_pcw;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
